// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the RV32M multiply/divide unit.
// Optional single-cycle multiply path is selected with FAST_MUL_EN.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  function automatic logic is_div(input op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_a(input op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV)  || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input op_e op);
    return (op == OP_MULH) || (op == OP_DIV) ||
           (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration bit: shift-add multiply or restoring-divide step
// on the packed {hi, lo} accumulator.
module muldiv_step #(
  parameter int W = 32
) (
  input  logic           mode_i,
  input  logic [W-1:0]   b_i,
  input  logic [2*W-1:0] acc_i,
  output logic [2*W-1:0] acc_o
);
  import muldiv_pkg::*;

  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W:0]   sum;
  logic [W:0]   tmp;
  logic [W:0]   diff;

  assign hi = acc_i[2*W-1:W];
  assign lo = acc_i[W-1:0];

  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_i} : '0);
    tmp  = {hi, lo[W-1]};
    diff = tmp - {1'b0, b_i};
    acc_o = {sum, lo[W-1:1]};
    if (mode_i == MODE_DIV) begin
      // borrow out means divisor did not fit: restore
      if (diff[W])
        acc_o = {tmp[W-1:0], lo[W-2:0], 1'b0};
      else
        acc_o = {diff[W-1:0], lo[W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Execute-stage RV32M iterative multiply/divide unit.
// Define FAST_MUL_EN for a single-cycle combinational multiply path.
module muldiv_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] src_a_i,
  input  logic [DATA_WIDTH-1:0] src_b_i,
  input  logic                  flush_i,
  output logic                  ready_o,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);
  import muldiv_pkg::*;

  localparam int W  = DATA_WIDTH;
  localparam int N  = W / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  state_e         state_q, state_d;
  op_e            op_q, op_d;
  logic           neg_q, neg_d;
  logic           corner_q, corner_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   cval_q, cval_d;
  logic [W-1:0]   result_q, result_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  op_e          op_in;
  logic         sa, sb;
  logic [W-1:0] abs_a, abs_b;
  logic         div0, ovf;

  assign op_in = op_e'(op_i);
  assign sa    = is_signed_a(op_in) & src_a_i[W-1];
  assign sb    = is_signed_b(op_in) & src_b_i[W-1];
  assign abs_a = sa ? -src_a_i : src_a_i;
  assign abs_b = sb ? -src_b_i : src_b_i;
  assign div0  = is_div(op_in) & (src_b_i == '0);
  assign ovf   = ((op_in == OP_DIV) | (op_in == OP_REM)) &
                 (src_a_i == {1'b1, {(W-1){1'b0}}}) &
                 (src_b_i == '1);

`ifdef FAST_MUL_EN
  logic                sxa, sxb;
  logic signed [2*W+1:0] fast_prod;
  assign sxa = is_signed_a(op_in) & src_a_i[W-1];
  assign sxb = is_signed_b(op_in) & src_b_i[W-1];
  assign fast_prod = $signed({sxa, src_a_i}) *
                     $signed({sxb, src_b_i});
`endif

  logic [2*W-1:0] chain [0:BITS_PER_CYCLE];
  assign chain[0] = acc_q;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    muldiv_step #(.W(W)) u_step (
      .mode_i (is_div(op_q)),
      .b_i    (b_q),
      .acc_i  (chain[g]),
      .acc_o  (chain[g+1])
    );
  end

  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo, rem;
  logic [W-1:0]   fix;

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo      = acc_q[W-1:0];
  assign rem      = acc_q[2*W-1:W];

  always_comb begin
    fix = '0;
    unique case (1'b1)
      (op_q == OP_MUL):
        fix = prod_fix[W-1:0];
      (!is_div(op_q) && op_q != OP_MUL):
        fix = prod_fix[2*W-1:W];
      (is_div(op_q) && !is_rem(op_q)):
        fix = neg_q ? -quo : quo;
      is_rem(op_q):
        fix = neg_q ? -rem : rem;
      default:
        fix = '0;
    endcase
    if (corner_q)
      fix = cval_q;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    corner_d = corner_q;
    b_d      = b_q;
    cval_d   = cval_q;
    result_d = result_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (valid_i && !flush_i) begin
          op_d     = op_in;
          b_d      = abs_b;
          acc_d    = {{W{1'b0}}, abs_a};
          cnt_d    = CW'(N);
          neg_d    = is_rem(op_in) ? sa : (sa ^ sb);
          corner_d = div0 | ovf;
          cval_d   = '0;
          if (div0)
            cval_d = is_rem(op_in) ? src_a_i : '1;
          else if (ovf)
            cval_d = is_rem(op_in) ? '0 : src_a_i;
          state_d  = (div0 | ovf) ? DONE : CALC;
`ifdef FAST_MUL_EN
          if (!is_div(op_in)) begin
            acc_d   = fast_prod[2*W-1:0];
            neg_d   = 1'b0;
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d = chain[BITS_PER_CYCLE];
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1))
            state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!flush_i)
          result_d = fix;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      corner_q <= 1'b0;
      b_q      <= '0;
      cval_q   <= '0;
      result_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      corner_q <= corner_d;
      b_q      <= b_d;
      cval_q   <= cval_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign stall_o  = (valid_i & (state_q == IDLE) & ~flush_i) |
                    (state_q == CALC);
  // result is visible in the DONE cycle so the pipeline can advance
  assign done_o   = (state_q == DONE) & ~flush_i;
  assign result_o = done_o ? fix : result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (BITS_PER_CYCLE=1 and 4).
// Multiply latency expectation follows FAST_MUL_EN.
module tb_muldiv_unit;

`ifdef FAST_MUL_EN
  localparam int MLAT = 1;
`else
  localparam int MLAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid1, valid4;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        ready1, stall1, done1;
  logic        ready4, stall4, done4;
  logic [31:0] res1, res4;

  int nvec = 0;
  int nerr = 0;
  bit sel  = 1'b0;

  always #5 clk = ~clk;

  muldiv_unit #(.DATA_WIDTH(32), .BITS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid1), .op_i(op),
    .src_a_i(a), .src_b_i(b), .flush_i(flush),
    .ready_o(ready1), .stall_o(stall1), .done_o(done1),
    .result_o(res1)
  );

  muldiv_unit #(.DATA_WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid4), .op_i(op),
    .src_a_i(a), .src_b_i(b), .flush_i(flush),
    .ready_o(ready4), .stall_o(stall4), .done_o(done4),
    .result_o(res4)
  );

  logic        c_done, c_stall, c_ready;
  logic [31:0] c_res;
  assign c_done  = sel ? done4  : done1;
  assign c_stall = sel ? stall4 : stall1;
  assign c_ready = sel ? ready4 : ready1;
  assign c_res   = sel ? res4   : res1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic do_op(input bit s, input logic [2:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input int lat,
                       input string tag);
    int c;
    bit sbad;
    sel = s;
    @(negedge clk);
    op = o; a = x; b = y;
    if (s) valid4 = 1'b1; else valid1 = 1'b1;
    #1;
    chk({tag, "_c0stall"}, 32'(c_stall), 32'd1);
    @(posedge clk); #1;
    valid1 = 1'b0; valid4 = 1'b0;
    c = 1; sbad = 1'b0;
    while (!c_done && c < 200) begin
      if (!c_stall) sbad = 1'b1;
      @(posedge clk); #1;
      c++;
    end
    chk({tag, "_lat"}, 32'(c), 32'(lat));
    chk({tag, "_res"}, c_res, exp);
    chk({tag, "_busystall"}, 32'(sbad), 32'd0);
    chk({tag, "_donestall"}, 32'(c_stall), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_hold"}, c_res, exp);
    chk({tag, "_rdy"}, 32'(c_ready), 32'd1);
  endtask

  initial begin
    bit dbad;
    rst_n = 1'b0; valid1 = 1'b0; valid4 = 1'b0;
    op = 3'd0; a = '0; b = '0; flush = 1'b0;
    #12;
    chk("rst_res", res1, 32'h0);
    chk("rst_rdy", 32'(ready1), 32'd1);
    chk("rst_stall", 32'(stall1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op(0, 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MLAT, "mul");
    do_op(0, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, MLAT, "mulh");
    do_op(0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MLAT, "mulhu");
    do_op(0, 3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, MLAT, "mulhsu");
    do_op(0, 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, "div");
    do_op(0, 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, "rem");
    do_op(0, 3'd5, 32'd100, 32'd7, 32'd14, 33, "divu");
    do_op(0, 3'd7, 32'd100, 32'd7, 32'd2, 33, "remu");

    // flush a DIV at C10, then accept a MUL at C11
    sel = 1'b0;
    @(negedge clk);
    op = 3'd4; a = 32'd100; b = 32'd7; valid1 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0; dbad = 1'b0;
    repeat (9) begin
      if (done1) dbad = 1'b1;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    #1;
    chk("fl_done_c10", 32'(done1), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_nodone", 32'(dbad | done1), 32'd0);
    chk("fl_rdy_c11", 32'(ready1), 32'd1);
    chk("fl_res_kept", res1, 32'd2);
    do_op(0, 3'd0, 32'd3, 32'd4, 32'd12, MLAT, "fl_mul");

    do_op(0, 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "divu0");
    do_op(0, 3'd6, 32'd5, 32'd0, 32'd5, 1, "rem0");
    do_op(0, 3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "div0");
    do_op(0, 3'd7, 32'd9, 32'd0, 32'd9, 1, "remu0");
    do_op(0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "divovf");
    do_op(0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, "removf");
    do_op(0, 3'd4, 32'h80000000, 32'h00000001, 32'h80000000, 33, "divmin1");
    do_op(0, 3'd6, 32'd7, 32'hFFFFFFFE, 32'd1, 33, "rempos");

    // async reset during an operation
    sel = 1'b0;
    @(negedge clk);
    op = 3'd5; a = 32'd100; b = 32'd7; valid1 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_res", res1, 32'h0);
    chk("mid_rst_rdy", 32'(ready1), 32'd1);
    chk("mid_rst_done", 32'(done1), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    do_op(0, 3'd5, 32'd100, 32'd7, 32'd14, 33, "post_rst");

    do_op(1, 3'd5, 32'hFFFFFFFF, 32'd3, 32'h55555555, 9, "b4_divu");
    do_op(1, 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 9, "b4_rem");
    do_op(1, 3'd0, 32'd7, 32'd6, 32'd42, (MLAT == 1) ? 1 : 9, "b4_mul");
    do_op(1, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000,
          (MLAT == 1) ? 1 : 9, "b4_mulh");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Execute-stage RV32M multiply/divide unit. It sits beside the ALU and receives operands after the forwarding muxes (SrcA/SrcB).
- Multi-cycle iterative datapath with a valid/ready handshake and a stall output to the hazard unit.
- Generalised in data width and in bits retired per cycle.
- Implements all eight M-extension ops with RISC-V-mandated corner-case results.

Parameters:
- DATA_WIDTH, 32, operand/result width (must be even, ≥8).
- BITS_PER_CYCLE, 1, quotient/multiplier bits processed per iteration; must be 1, 2 or 4 and must divide DATA_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  M-op present in Execute this cycle.
- op_i  in  3  op code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- src_a_i  in  DATA_WIDTH  forwarded rs1.
- src_b_i  in  DATA_WIDTH  forwarded rs2.
- flush_i  in  1  synchronous abort (branch mispredict / FlushE).
- ready_o  out  1  unit idle, can accept.
- stall_o  out  1  hold Fetch/Decode/Execute.
- done_o  out  1  result valid, one-cycle pulse.
- result_o  out  DATA_WIDTH  result, held until the next accept.

Behaviour:
- Reset (async, rst_n=0): state IDLE; done_o=0; result_o=0; all internal regs 0; ready_o=1; stall_o=0. Takes effect immediately, including mid-operation; the in-flight op is lost.
- States: IDLE, CALC, DONE.
- ready_o = (state==IDLE).
- Accept cycle C0 = valid_i & ready_o & ~flush_i.
  - Latch op.
  - Signed ops (MULH: both operands; MULHSU: src_a only; DIV/REM: both) store absolute values and record the result sign.
  - Load counter N = DATA_WIDTH/BITS_PER_CYCLE.
- Corner cases are detected at accept and jump straight to DONE (result in C1):
  - Divide by zero (src_b=0): DIV/DIVU result all-ones; REM/REMU result src_a.
  - Signed overflow (src_a = most-negative, src_b = all-ones, DIV/REM): DIV result src_a; REM result 0.
- CALC runs cycles C1..CN.
  - Multiply: shift-add into a 2·DATA_WIDTH accumulator, BITS_PER_CYCLE multiplier bits per cycle.
  - Divide: restoring division, BITS_PER_CYCLE quotient bits per cycle.
  - Counter decrements each cycle; leave CALC when counter hits 1.
- DONE runs in cycle C(N+1).
  - Apply sign fix-up: two's-complement negate if the recorded sign is 1.
    - Product sign = signA XOR signB.
    - Quotient sign = signA XOR signB.
    - Remainder sign = signA.
  - Select the result: MUL = low half; MULH* = high half; DIV* = quotient; REM* = remainder.
  - Register result_o; done_o=1 for exactly this cycle; return to IDLE.
- Latency: default parameters give done at C33; corner cases give done at C1.
- stall_o = (valid_i & state==IDLE & ~flush_i) | (state==CALC).
  - stall_o is low in DONE so the pipeline advances with result_o.
  - Back-to-back ops: the next op is accepted in the cycle after DONE.
- flush_i in CALC or DONE: next state IDLE, done_o stays 0, result_o unchanged.
- flush_i with valid_i in IDLE: op not accepted.
- flush_i has priority over every other transition.
- valid_i while busy: ignored; stall_o already holds the upstream stages.

Optional Feature:
- Macro FAST_MUL_EN.
  - Defined: MUL/MULH/MULHSU/MULHU use a single combinational DATA_WIDTH×DATA_WIDTH signed-extended multiplier and go IDLE→DONE, giving done at C1. Divides are unchanged.
  - Undefined: all multiplies are iterative as above. No multiplier array is inferred.

Decomposition:
- Package muldiv_pkg holds:
  - op typedef enum logic [2:0] (MUL..REMU).
  - state typedef enum {IDLE, CALC, DONE}.
  - helper functions is_div(op), is_signed_a(op), is_signed_b(op).
- Sub-module muldiv_step: combinational single-bit iteration (add-shift or restore-subtract, selected by a mode input). It is instantiated BITS_PER_CYCLE times in a generate chain inside muldiv_unit.

Test Plan (DATA_WIDTH=32, BITS_PER_CYCLE=1 unless noted):
1. MUL 7 × 0xFFFFFFFD (−3) → result 0xFFFFFFEB; done_o at C33; stall_o high C0..C32, low C33.
2. MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
3. DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
4. Corner cases: DIVU 5/0 → 0xFFFFFFFF at C1; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0; all at C1.
5. Flush and reset:
   - flush_i at C10 of DIV → no done_o; ready_o=1 at C11; a new MUL 3×4 is accepted at C11 → 12 at C44.
   - rst_n low at C5 → result_o=0 and ready_o=1 immediately.
6. Parameter and macro sweep: BITS_PER_CYCLE=4, DIVU 0xFFFFFFFF/3 → 0x55555555 with done at C9. FAST_MUL_EN defined: MUL 7×6 → 42 at C1.
